hist_frame_analyzer: RTL and testbench
======================================

Name: hist_frame_analyzer

Overview:
- Sits directly downstream of the 64-bin histogramming stage.
- Consumes its per-frame bin stream: valid/last strobes plus a 4-bit count per bin, delivered in bin order 0..63.
- Buffers the frame and computes summary statistics: peak bin, peak count, total, non-zero bin count and median bin.
- Presents results through a hold-until-acknowledged interface to the readout/IO logic.

Parameters:
- NBINS, 64, number of bins per frame. Bin index width IDXW = 6.
- CW, 4, bin count width. Saturated count = 15.
- TOTW, 10, total-sum width. Must hold NBINS*(2^CW-1) = 960.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  bin beat strobe from histogram stage
- in_last  input  1  marks final beat (bin 63) of a frame
- in_count  input  CW  count of current bin
- in_ready  output  1  high when beats are accepted (COLLECT state)
- result_valid  output  1  statistics available; held until result_ack
- result_ack  input  1  consumer acknowledge; clears result_valid
- peak_bin  output  IDXW  index of largest count
- peak_count  output  CW  largest count
- total  output  TOTW  sum of all 64 counts
- nonzero_bins  output  7  number of bins with count != 0 (0..64)
- median_bin  output  IDXW  smallest k with 2*cumsum(0..k) >= total
- frame_err  output  1  sticky: malformed frame seen
- overrun  output  1  sticky: beat dropped, or result overwritten before ack

Behaviour:
- Reset values (async, rst_n low):
  - state = COLLECT, in_ready = 1, all result outputs 0, result_valid = 0, frame_err = 0, overrun = 0.
  - Beat index 0, accumulators 0.
  - Buffer RAM contents are don't-care.
- COLLECT state, on each in_valid beat:
  - Write in_count to buffer[idx].
  - Add in_count to running total.
  - Increment the non-zero count if in_count != 0.
  - Update the running peak if in_count > peak (strict compare; ties keep the lower index).
  - idx increments by 1 per beat.
- Frame termination:
  - in_last with idx == 63: go to SCAN next cycle; in_ready = 0.
  - in_last with idx != 63, or a beat at idx == 63 without in_last: set frame_err, discard the frame (accumulators and idx cleared), stay in COLLECT.
- SCAN state:
  - One buffer entry per cycle, starting at 0, accumulating cumsum.
  - The first k with 2*cumsum >= total sets median_bin and ends the scan.
  - If total == 0, the median resolves to 0 on the first cycle.
  - Scan length is k+1 cycles, at most 64.
  - On exit, register peak_bin, peak_count, total, nonzero_bins and median_bin together, and set result_valid.
  - If result_valid was already high at exit, set overrun.
  - Return to COLLECT with in_ready = 1.
- Latency: results appear at most 66 cycles after the in_last beat.
- Result handshake:
  - Result outputs are stable while result_valid = 1.
  - result_ack with result_valid = 1 clears result_valid next cycle.
  - result_ack while result_valid = 0 is ignored.
  - If ack and scan exit coincide, the new result wins: result_valid stays 1, no overrun.
- Backpressure and flags:
  - The upstream block has no backpressure. An in_valid beat during SCAN is dropped and sets overrun.
  - frame_err and overrun clear only on rst_n.
- Reset mid-frame or mid-scan aborts all activity and restores reset values.

Test Plan:
- Frame with bin i = i mod 16 (0..15 repeating), in_last on beat 63 -> peak_bin=15, peak_count=15, total=480, nonzero_bins=60, median_bin=31, result_valid held until result_ack, then 0.
- All-zero frame -> total=0, peak_bin=0, peak_count=0, nonzero_bins=0, median_bin=0, result within 2 cycles of in_last.
- Single bin 40 = 15, rest 0 -> peak_bin=40, median_bin=40, nonzero_bins=1, total=15. Ties: bins 5 and 9 both 7 -> peak_bin=5.
- in_last asserted on beat 30 -> frame_err=1, no result_valid. The following correct frame is analysed normally.
- in_valid pulsed during SCAN -> overrun=1, beat ignored. Second frame completes without ack -> overrun=1, outputs show second frame.
- rst_n low mid-SCAN -> all outputs return to reset values, in_ready=1. The next frame is processed correctly.

Source files
------------

// File: rtl/hist_frame_analyzer.sv
// Buffers one 64-bin histogram frame, then scans it to produce peak, total,
// non-zero count and median statistics behind a hold-until-ack result port.
module hist_frame_analyzer #(
   parameter int NBINS = 64,
   parameter int CW    = 4,
   parameter int TOTW  = 10,
   parameter int IDXW  = $clog2(NBINS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            in_last,
   input  logic [CW-1:0]   in_count,
   output logic            in_ready,
   output logic            result_valid,
   input  logic            result_ack,
   output logic [IDXW-1:0] peak_bin,
   output logic [CW-1:0]   peak_count,
   output logic [TOTW-1:0] total,
   output logic [IDXW:0]   nonzero_bins,
   output logic [IDXW-1:0] median_bin,
   output logic            frame_err,
   output logic            overrun
);

   // Handshakes: an input beat is taken on any cycle with in_valid && in_ready
   // (upstream never waits, so beats with in_ready low are lost and flagged);
   // a result is offered while result_valid is high and retired by result_ack.

   typedef enum logic {
      COLLECT = 1'b0,
      SCAN    = 1'b1
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBINS - 1);

   state_t state, state_nxt;

   logic [CW-1:0]   buf_mem [NBINS];

   logic [IDXW-1:0] idx;
   logic [TOTW-1:0] acc_total;
   logic [IDXW:0]   acc_nz;
   logic [CW-1:0]   acc_peak;
   logic [IDXW-1:0] acc_peak_bin;

   logic [IDXW-1:0] scan_idx;
   logic [TOTW-1:0] cumsum;

   logic            beat;
   logic            at_end;
   logic            frame_ok;
   logic            frame_bad;
   logic [CW-1:0]   scan_cnt;
   logic [TOTW-1:0] cum_nxt;
   logic            median_hit;
   logic            scan_done;

   assign in_ready  = (state == COLLECT);
   assign beat      = in_valid && (state == COLLECT);
   assign at_end    = (idx == LAST_IDX);
   assign frame_ok  = beat && in_last && at_end;
   assign frame_bad = beat && (in_last != at_end);

   assign scan_cnt  = buf_mem[scan_idx];
   assign cum_nxt   = cumsum + TOTW'(scan_cnt);
   // Doubling cumsum avoids a divide; the last bin always satisfies it anyway.
   assign median_hit = ({cum_nxt, 1'b0} >= {1'b0, acc_total}) || (scan_idx == LAST_IDX);
   assign scan_done  = (state == SCAN) && median_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (frame_ok)   state_nxt = SCAN;
         SCAN:    if (median_hit) state_nxt = COLLECT;
         default:                 state_nxt = COLLECT;
      endcase
   end

   // Frame buffer carries no reset; its contents are only read after a full frame.
   always_ff @(posedge clk) begin
      if (beat) begin
         buf_mem[idx] <= in_count;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         acc_total    <= '0;
         acc_nz       <= '0;
         acc_peak     <= '0;
         acc_peak_bin <= '0;
         scan_idx     <= '0;
         cumsum       <= '0;
         result_valid <= 1'b0;
         peak_bin     <= '0;
         peak_count   <= '0;
         total        <= '0;
         nonzero_bins <= '0;
         median_bin   <= '0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (frame_bad) begin
            frame_err    <= 1'b1;
            idx          <= '0;
            acc_total    <= '0;
            acc_nz       <= '0;
            acc_peak     <= '0;
            acc_peak_bin <= '0;
         end else if (beat) begin
            idx       <= idx + IDXW'(1);
            acc_total <= acc_total + TOTW'(in_count);
            if (in_count != '0) begin
               acc_nz <= acc_nz + (IDXW+1)'(1);
            end
            // Strict compare keeps the lowest index on ties.
            if (in_count > acc_peak) begin
               acc_peak     <= in_count;
               acc_peak_bin <= idx;
            end
         end

         if ((state == SCAN) && in_valid) begin
            overrun <= 1'b1;
         end

         if (state == SCAN) begin
            cumsum   <= cum_nxt;
            scan_idx <= scan_idx + IDXW'(1);
         end

         if (scan_done) begin
            peak_bin     <= acc_peak_bin;
            peak_count   <= acc_peak;
            total        <= acc_total;
            nonzero_bins <= acc_nz;
            median_bin   <= scan_idx;
            result_valid <= 1'b1;
            if (result_valid && !result_ack) begin
               overrun <= 1'b1;
            end
            idx          <= '0;
            acc_total    <= '0;
            acc_nz       <= '0;
            acc_peak     <= '0;
            acc_peak_bin <= '0;
            scan_idx     <= '0;
            cumsum       <= '0;
         end else if (result_ack) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hist_frame_analyzer.sv
// Self-checking bench for hist_frame_analyzer: fixed pattern table, random
// frames against a plain-arithmetic reference, and multi-cycle corner sequences.
module tb_hist_frame_analyzer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_last;
   logic [3:0] in_count;
   logic       in_ready;
   logic       result_valid;
   logic       result_ack;
   logic [5:0] peak_bin;
   logic [3:0] peak_count;
   logic [9:0] total;
   logic [6:0] nonzero_bins;
   logic [5:0] median_bin;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   int frame_buf [64];
   int m_peak_bin, m_peak_count, m_total, m_nz, m_median;

   typedef struct {
      int kind;
      int e_peak_bin;
      int e_peak_count;
      int e_total;
      int e_nz;
      int e_median;
   } vec_t;

   vec_t vecs [4];

   hist_frame_analyzer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_count     (in_count),
      .in_ready     (in_ready),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .peak_bin     (peak_bin),
      .peak_count   (peak_count),
      .total        (total),
      .nonzero_bins (nonzero_bins),
      .median_bin   (median_bin),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // Reference statistics straight from the definitions.
   task automatic model_frame();
      int cum;
      m_total = 0; m_nz = 0; m_peak_bin = 0; m_peak_count = -1; m_median = -1;
      foreach (frame_buf[i]) begin
         m_total += frame_buf[i];
         if (frame_buf[i] != 0) m_nz++;
         if (frame_buf[i] > m_peak_count) begin
            m_peak_count = frame_buf[i];
            m_peak_bin   = i;
         end
      end
      cum = 0;
      for (int k = 0; k < 64; k++) begin
         cum += frame_buf[k];
         if (m_median < 0 && 2 * cum >= m_total) m_median = k;
      end
   endtask

   task automatic fill_pattern(input int kind);
      foreach (frame_buf[i]) frame_buf[i] = 0;
      case (kind)
         0: foreach (frame_buf[i]) frame_buf[i] = i % 16;
         1: ;
         2: frame_buf[40] = 15;
         3: begin frame_buf[5] = 7; frame_buf[9] = 7; end
         default: foreach (frame_buf[i])
            frame_buf[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
      endcase
   endtask

   // Drives n beats from frame_buf, in_last on beat last_at, then idles.
   task automatic drive_beats(input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_count = 4'(frame_buf[i]);
         in_last  = (i == last_at);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_count = '0;
   endtask

   task automatic wait_result(input int limit, output int cyc);
      cyc = 1;
      while (!result_valid && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      chk("result_valid_arrives", int'(result_valid), 1);
   endtask

   task automatic chk_outputs(input string tag, input int pb, input int pc,
                              input int tot, input int nz, input int med);
      chk({tag, "_peak_bin"},     int'(peak_bin),     pb);
      chk({tag, "_peak_count"},   int'(peak_count),   pc);
      chk({tag, "_total"},        int'(total),        tot);
      chk({tag, "_nonzero_bins"}, int'(nonzero_bins), nz);
      chk({tag, "_median_bin"},   int'(median_bin),   med);
   endtask

   task automatic chk_model(input string tag);
      chk_outputs(tag, m_peak_bin, m_peak_count, m_total, m_nz, m_median);
   endtask

   task automatic do_ack();
      @(negedge clk);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk("ack_clears_valid", int'(result_valid), 0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},     int'(in_ready),     1);
      chk({tag, "_result_valid"}, int'(result_valid), 0);
      chk({tag, "_frame_err"},    int'(frame_err),    0);
      chk({tag, "_overrun"},      int'(overrun),      0);
      chk_outputs(tag, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int cyc;
      int held_total;

      vecs[0] = '{0, 15, 15, 480, 60, 31};
      vecs[1] = '{1,  0,  0,   0,  0,  0};
      vecs[2] = '{2, 40, 15,  15,  1, 40};
      vecs[3] = '{3,  5,  7,  14,  2,  5};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_count = '0; result_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Fixed pattern table
      foreach (vecs[v]) begin
         fill_pattern(vecs[v].kind);
         drive_beats(64, 63);
         wait_result(70, cyc);
         chk_outputs($sformatf("vec%0d", v), vecs[v].e_peak_bin, vecs[v].e_peak_count,
                     vecs[v].e_total, vecs[v].e_nz, vecs[v].e_median);
         if (vecs[v].kind == 1) chk("zero_frame_latency_ok", int'(cyc <= 2), 1);
         held_total = int'(total);
         repeat (4) @(negedge clk);
         chk("result_held_valid", int'(result_valid), 1);
         chk("result_held_total", int'(total), held_total);
         do_ack();
      end

      // Random frames against the reference
      for (int r = 0; r < 16; r++) begin
         fill_pattern(9);
         model_frame();
         drive_beats(64, 63);
         wait_result(70, cyc);
         chk_model($sformatf("rand%0d", r));
         chk("rand_latency_ok", int'(cyc <= 66), 1);
         do_ack();
      end
      chk("no_spurious_overrun", int'(overrun), 0);

      // Short frame: in_last on beat 30
      fill_pattern(0);
      drive_beats(31, 30);
      repeat (70) @(negedge clk);
      chk("short_frame_err", int'(frame_err), 1);
      chk("short_no_result", int'(result_valid), 0);
      chk("short_in_ready", int'(in_ready), 1);
      fill_pattern(2);
      drive_beats(64, 63);
      wait_result(70, cyc);
      chk_outputs("after_err", 40, 15, 15, 1, 40);
      do_ack();

      // Beat 63 without in_last, then a recovery frame
      fill_pattern(3);
      drive_beats(64, 99);
      repeat (70) @(negedge clk);
      chk("missing_last_no_result", int'(result_valid), 0);
      fill_pattern(9);
      model_frame();
      drive_beats(64, 63);
      wait_result(70, cyc);
      chk_model("after_missing_last");
      chk("no_overrun_yet", int'(overrun), 0);
      do_ack();

      // Beat during SCAN is dropped and flagged
      fill_pattern(0);
      drive_beats(64, 63);
      @(negedge clk);
      chk("scan_in_ready_low", int'(in_ready), 0);
      in_valid = 1'b1; in_count = 4'd15;
      @(negedge clk);
      in_valid = 1'b0; in_count = '0;
      wait_result(70, cyc);
      chk("scan_beat_overrun", int'(overrun), 1);
      chk_outputs("scan_beat", 15, 15, 480, 60, 31);
      do_ack();
      fill_pattern(9);
      model_frame();
      drive_beats(64, 63);
      wait_result(70, cyc);
      chk_model("after_dropped_beat");
      do_ack();

      // Reset in the middle of SCAN
      fill_pattern(0);
      drive_beats(64, 63);
      repeat (3) @(negedge clk);
      chk("midscan_in_ready_low", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      chk_reset_values("midscan_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_pattern(9);
      model_frame();
      drive_beats(64, 63);
      wait_result(70, cyc);
      chk_model("after_reset");
      do_ack();

      // Second result overwrites an unacknowledged first one
      fill_pattern(2);
      drive_beats(64, 63);
      wait_result(70, cyc);
      chk("first_no_overrun", int'(overrun), 0);
      fill_pattern(9);
      model_frame();
      drive_beats(64, 63);
      repeat (70) @(negedge clk);
      chk("overwrite_valid", int'(result_valid), 1);
      chk("overwrite_overrun", int'(overrun), 1);
      chk("overwrite_frame_err", int'(frame_err), 0);
      chk_model("overwrite");
      do_ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
